viterbi_acs_seq: RTL and testbench

VITERBI_ACS_SEQ -- requirements
Module: viterbi_acs_seq

---
 rtl/viterbi_pkg.sv | 29 ++
 rtl/acs_butterfly.sv | 48 ++++
 rtl/viterbi_acs_seq.sv | 142 ++++++++++++++
 tb/tb_viterbi_acs_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=7 rate-1/2 Viterbi ACS.
// Generators are 133/171 (octal).
package viterbi_pkg;

  localparam int M = 6;
  localparam int NSTATES = 64;
  localparam logic [6:0] POLY_A = 7'o133;
  localparam logic [6:0] POLY_B = 7'o171;
  localparam logic [M:0] SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_t;

  // Hamming distance between branch output of w = {b, s} and symbol pair
  function automatic logic [1:0] branch_metric(
    input logic [6:0] w,
    input logic [1:0] s
  );
    logic a;
    logic b;
    a = ^(w & POLY_A) ^ s[1];
    b = ^(w & POLY_B) ^ s[0];
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/acs_butterfly.sv
// One radix-2 add-compare-select butterfly.
// Predecessors 2j, 2j+1 feed successors j (b=0) and j+32 (b=1).
module acs_butterfly #(
  parameter int M = viterbi_pkg::M
) (
  input  logic [4:0] i_j,
  input  logic [M:0] i_pm_even,
  input  logic [M:0] i_pm_odd,
  input  logic [1:0] i_sym,
  output logic [M:0] o_nm_lo,
  output logic [M:0] o_nm_hi,
  output logic       o_d_lo,
  output logic       o_d_hi
);
  import viterbi_pkg::*;

  localparam logic [M:0] SATV = {(M+1){1'b1}};

  // Near-saturated metrics pin to SAT so the sum never wraps
  function automatic logic [M:0] add_sat(
    input logic [M:0] pm,
    input logic [1:0] bm
  );
    if (&pm[M:1]) return SATV;
    return pm + {{(M-1){1'b0}}, bm};
  endfunction

  logic [M:0] w_c_e0;
  logic [M:0] w_c_o0;
  logic [M:0] w_c_e1;
  logic [M:0] w_c_o1;

  always_comb begin
    w_c_e0 = add_sat(i_pm_even,
      branch_metric({1'b0, i_j, 1'b0}, i_sym));
    w_c_o0 = add_sat(i_pm_odd,
      branch_metric({1'b0, i_j, 1'b1}, i_sym));
    w_c_e1 = add_sat(i_pm_even,
      branch_metric({1'b1, i_j, 1'b0}, i_sym));
    w_c_o1 = add_sat(i_pm_odd,
      branch_metric({1'b1, i_j, 1'b1}, i_sym));
    o_d_lo  = w_c_o0 < w_c_e0;
    o_d_hi  = w_c_o1 < w_c_e1;
    o_nm_lo = o_d_lo ? w_c_o0 : w_c_e0;
    o_nm_hi = o_d_hi ? w_c_o1 : w_c_e1;
  end

endmodule

// File: rtl/viterbi_acs_seq.sv
// Sequential Viterbi ACS: one butterfly per cycle, 32 cycles per step,
// ping-pong metric banks and a handshake on decisions.
module viterbi_acs_seq #(
  parameter int M = viterbi_pkg::M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         sym_valid,
  input  logic [1:0]   sym,
  output logic         sym_ready,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic [63:0]  dec,
  output logic [5:0]   best_state,
  output logic [M:0]   best_metric
);
  import viterbi_pkg::*;

  localparam logic [M:0] SATV = {(M+1){1'b1}};
  localparam logic [M:0] HALF = {1'b1, {M{1'b0}}};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [1:0]  r_sym;
  logic        r_sel;
  logic        r_norm;
  logic [63:0] r_dec;
  logic [5:0]  r_best_state;
  logic [M:0]  r_best_metric;
  logic [M:0]  r_bank [2][NSTATES];

  logic        w_init;
  logic        w_accept;
  logic [M:0]  w_rd_even;
  logic [M:0]  w_rd_odd;
  logic [M:0]  w_pm_even;
  logic [M:0]  w_pm_odd;
  logic [M:0]  w_nm_lo;
  logic [M:0]  w_nm_hi;
  logic        w_d_lo;
  logic        w_d_hi;
  logic [M:0]  w_loc_m;
  logic [5:0]  w_loc_s;
  logic        w_take;
  logic [M:0]  w_bm_nxt;
  logic [5:0]  w_bs_nxt;

  assign w_init   = !rst_n || clear;
  assign w_accept = sym_valid && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (w_init) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (sym_valid) w_state_nxt = RUN;
      RUN:     if (r_cnt == 5'd31) w_state_nxt = OUT;
      OUT:     if (dec_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sym_ready = 1'b0;
    dec_valid = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): sym_ready = 1'b1;
      (r_state == OUT):  dec_valid = 1'b1;
      default: ;
    endcase
  end

  // Normalisation is applied on the read side of the old bank
  assign w_rd_even = r_bank[r_sel][{r_cnt, 1'b0}];
  assign w_rd_odd  = r_bank[r_sel][{r_cnt, 1'b1}];
  assign w_pm_even = (r_norm && w_rd_even != SATV) ?
                     w_rd_even - HALF : w_rd_even;
  assign w_pm_odd  = (r_norm && w_rd_odd != SATV) ?
                     w_rd_odd - HALF : w_rd_odd;

  acs_butterfly #(.M(M)) u_bfly (
    .i_j       (r_cnt),
    .i_pm_even (w_pm_even),
    .i_pm_odd  (w_pm_odd),
    .i_sym     (r_sym),
    .o_nm_lo   (w_nm_lo),
    .o_nm_hi   (w_nm_hi),
    .o_d_lo    (w_d_lo),
    .o_d_hi    (w_d_hi)
  );

  // States are visited out of index order, so ties compare the index
  always_comb begin
    w_loc_m  = (w_nm_lo <= w_nm_hi) ? w_nm_lo : w_nm_hi;
    w_loc_s  = (w_nm_lo <= w_nm_hi) ? {1'b0, r_cnt} : {1'b1, r_cnt};
    w_take   = (r_cnt == 5'd0) || (w_loc_m < r_best_metric) ||
               ((w_loc_m == r_best_metric) && (w_loc_s < r_best_state));
    w_bm_nxt = w_take ? w_loc_m : r_best_metric;
    w_bs_nxt = w_take ? w_loc_s : r_best_state;
  end

  always_ff @(posedge clk) begin
    if (w_init) begin
      for (int k = 0; k < NSTATES; k++) begin
        r_bank[0][k] <= (k == 0) ? '0 : SATV;
        r_bank[1][k] <= (k == 0) ? '0 : SATV;
      end
      r_sel         <= 1'b0;
      r_cnt         <= '0;
      r_sym         <= '0;
      r_norm        <= 1'b0;
      r_dec         <= '0;
      r_best_state  <= '0;
      r_best_metric <= '0;
    end else begin
      if (w_accept) r_sym <= sym;
      if (r_state == RUN) begin
        r_bank[~r_sel][{1'b0, r_cnt}] <= w_nm_lo;
        r_bank[~r_sel][{1'b1, r_cnt}] <= w_nm_hi;
        r_dec[{1'b0, r_cnt}] <= w_d_lo;
        r_dec[{1'b1, r_cnt}] <= w_d_hi;
        r_cnt         <= r_cnt + 5'd1;
        r_best_state  <= w_bs_nxt;
        r_best_metric <= w_bm_nxt;
        if (r_cnt == 5'd31) begin
          r_sel  <= ~r_sel;
          r_norm <= w_bm_nxt[M];
        end
      end
    end
  end

  assign dec         = r_dec;
  assign best_state  = r_best_state;
  assign best_metric = r_best_metric;

endmodule

// File: tb/tb_viterbi_acs_seq.sv
// Self-checking bench for viterbi_acs_seq.
// Table of encoded steps plus directed multi-cycle sequences.
module tb_viterbi_acs_seq;
  import viterbi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym = 2'b00;
  logic        dec_ready = 1'b0;
  logic        sym_ready;
  logic        dec_valid;
  logic [63:0] dec;
  logic [5:0]  best_state;
  logic [6:0]  best_metric;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  viterbi_acs_seq #(.M(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .sym_ready   (sym_ready),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec         (dec),
    .best_state  (best_state),
    .best_metric (best_metric)
  );

  typedef struct {
    logic [1:0] sym;
    logic [5:0] bs;
    logic [6:0] bm;
  } vec_t;

  vec_t vec [20];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic int count_sat();
    int n = 0;
    for (int k = 0; k < 64; k++)
      if (dut.r_bank[dut.r_sel][k] == 7'h7f) n++;
    return n;
  endfunction

  function automatic int count_big();
    int n = 0;
    for (int k = 0; k < 64; k++)
      if (dut.r_bank[dut.r_sel][k] != 7'h7f &&
          dut.r_bank[dut.r_sel][k] > 7'd64) n++;
    return n;
  endfunction

  function automatic logic [6:0] metric(input int k);
    return dut.r_bank[dut.r_sel][k];
  endfunction

  task automatic start_step(input logic [1:0] s);
    int n = 0;
    while (!sym_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 100), 64'd1);
    sym = s;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    sym = ~s;
  endtask

  task automatic run_step(input logic [1:0] s, output int lat);
    start_step(s);
    lat = 1;
    while (!dec_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("dec_valid_wait", 64'(lat < 100), 64'd1);
  endtask

  task automatic release_dec();
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [5:0]  s;
    logic        b;
    logic [6:0]  w;
    logic [19:0] bits;
    logic [63:0] h_dec;
    logic [5:0]  h_bs;
    logic [6:0]  h_bm;
    logic [6:0]  prev;
    logic        ok_dec;
    logic        ok_bs;
    logic        ok_bm;
    logic        ok_rdy;

    bits = 20'hB38D6;
    s = '0;
    for (int i = 0; i < 20; i++) begin
      b = bits[i];
      w = {b, s};
      vec[i].sym = {^(w & 7'b1011011), ^(w & 7'b1111001)};
      s = {b, s[5:1]};
      vec[i].bs = s;
      vec[i].bm = 7'd0;
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sym_ready", 64'(sym_ready), 64'd1);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec", dec, 64'd0);
    chk("rst_best_state", 64'(best_state), 64'd0);
    chk("rst_best_metric", 64'(best_metric), 64'd0);
    chk("rst_pm0", 64'(metric(0)), 64'd0);
    chk("rst_sat_cnt", 64'(count_sat()), 64'd63);

    run_step(2'b00, lat);
    chk("s1_latency", 64'(lat), 64'd33);
    chk("s1_best_state", 64'(best_state), 64'd0);
    chk("s1_best_metric", 64'(best_metric), 64'd0);
    chk("s1_dec0", 64'(dec[0]), 64'd0);
    chk("s1_pm32", 64'(metric(32)), 64'd2);
    chk("s1_sat_cnt", 64'(count_sat()), 64'd62);
    release_dec();

    run_step(2'b00, lat);
    chk("s2_best_metric", 64'(best_metric), 64'd0);
    chk("s2_pm16", 64'(metric(16)), 64'd3);
    chk("s2_pm48", 64'(metric(48)), 64'd3);
    chk("s2_pm32", 64'(metric(32)), 64'd2);
    chk("s2_sat_cnt", 64'(count_sat()), 64'd60);
    release_dec();

    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      run_step(vec[i].sym, lat);
      if (i == 0) chk("enc_latency", 64'(lat), 64'd33);
      chk($sformatf("enc%0d_state", i), 64'(best_state), 64'(vec[i].bs));
      chk($sformatf("enc%0d_metric", i), 64'(best_metric), 64'(vec[i].bm));
      if (i < 19) release_dec();
    end

    h_dec = dec;
    h_bs = best_state;
    h_bm = best_metric;
    ok_dec = 1'b1;
    ok_bs = 1'b1;
    ok_bm = 1'b1;
    ok_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dec !== h_dec) ok_dec = 1'b0;
      if (best_state !== h_bs) ok_bs = 1'b0;
      if (best_metric !== h_bm) ok_bm = 1'b0;
      if (sym_ready !== 1'b0 || dec_valid !== 1'b1) ok_rdy = 1'b0;
    end
    chk("hold_dec", 64'(ok_dec), 64'd1);
    chk("hold_best_state", 64'(ok_bs), 64'd1);
    chk("hold_best_metric", 64'(ok_bm), 64'd1);
    chk("hold_not_ready", 64'(ok_rdy), 64'd1);
    release_dec();
    chk("hold_idle_ready", 64'(sym_ready), 64'd1);
    chk("hold_idle_valid", 64'(dec_valid), 64'd0);

    pulse_clear();
    seen = 0;
    while (best_metric < 7'd64 && seen < 1500) begin
      run_step(2'($urandom_range(3)), lat);
      release_dec();
      seen++;
    end
    chk("noise_reach64", 64'(best_metric >= 7'd64), 64'd1);
    prev = best_metric;
    run_step(2'($urandom_range(3)), lat);
    chk("norm_below66", 64'(best_metric < 7'd66), 64'd1);
    chk("norm_drop", 64'(best_metric <= prev - 7'd62), 64'd1);
    chk("norm_floor", 64'(best_metric >= prev - 7'd64), 64'd1);
    chk("norm_all_low", 64'(count_big()), 64'd0);
    release_dec();

    start_step(2'b11);
    repeat (9) @(negedge clk);
    pulse_clear();
    chk("clr_sym_ready", 64'(sym_ready), 64'd1);
    chk("clr_dec_valid", 64'(dec_valid), 64'd0);
    chk("clr_best_metric", 64'(best_metric), 64'd0);
    chk("clr_pm0", 64'(metric(0)), 64'd0);
    chk("clr_sat_cnt", 64'(count_sat()), 64'd63);
    ok_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dec_valid !== 1'b0) ok_rdy = 1'b0;
    end
    chk("clr_no_dec_valid", 64'(ok_rdy), 64'd1);
    run_step(2'b00, lat);
    chk("clr_step_latency", 64'(lat), 64'd33);
    chk("clr_step_pm32", 64'(metric(32)), 64'd2);
    chk("clr_step_best", 64'(best_metric), 64'd0);
    release_dec();

    start_step(2'b01);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstrun_dec_valid", 64'(dec_valid), 64'd0);
    chk("rstrun_sym_ready", 64'(sym_ready), 64'd1);
    chk("rstrun_best_metric", 64'(best_metric), 64'd0);
    chk("rstrun_dec", dec, 64'd0);
    ok_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dec_valid !== 1'b0) ok_rdy = 1'b0;
    end
    chk("rstrun_no_dec_valid", 64'(ok_rdy), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
